// File: rtl/pkt_disp_sched.sv
// pkt_disp_sched
//
// Queues result packets from the datapath and plays each one out, one hex
// nibble at a time (most significant first), on a single active-low
// 7-segment digit. A blank gap separates consecutive packets, and an internal
// prescaler paces the display so a person can read it.
//
// Ports
//   CLK        rising-edge clock
//   nRST       asynchronous active-low reset
//   PKT_VALID  PKT_DATA holds a packet to enqueue
//   PKT_DATA   packet payload, PACKET_W bits
//   PKT_READY  FIFO has room (decoded from the registered occupancy only)
//   PAUSE      freezes prescaler, hold counter and SHOW/GAP progress
//   nHEX       segments {g,f,e,d,c,b,a}, 0 = lit, 7'h7F = blank
//   DIGIT_IDX  index of the nibble on display, NIB-1 = most significant
//   BUSY       scheduler is not idle
//   FIFO_CNT   number of queued packets
module pkt_disp_sched #(
    parameter  int PACKET_W = 32,
    parameter  int DEPTH    = 4,
    parameter  int DIV      = 1_000_000,
    parameter  int HOLD     = 25,
    localparam int NIB      = PACKET_W / 4,
    localparam int IDX_W    = (NIB > 1) ? $clog2(NIB) : 1,
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                PKT_VALID,
    input  logic [PACKET_W-1:0] PKT_DATA,
    output logic                PKT_READY,
    input  logic                PAUSE,
    output logic [6:0]          nHEX,
    output logic [IDX_W-1:0]    DIGIT_IDX,
    output logic                BUSY,
    output logic [CNT_W-1:0]    FIFO_CNT
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int PS_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int HC_W  = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(DIV - 1);
    localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(HOLD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHOW,
        S_GAP
    } state_t;

    state_t state, state_next;

    logic [PACKET_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    cnt;
    logic [PACKET_W-1:0] pkt;
    logic [IDX_W-1:0]    digit_idx;
    logic [PS_W-1:0]     ps_cnt;
    logic [HC_W-1:0]     hold_cnt;
    logic [3:0]          nib;

    logic push, pop;
    logic active, run, tick, phase_end;

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0:    return 7'b1000000;
            4'h1:    return 7'b1111001;
            4'h2:    return 7'b0100100;
            4'h3:    return 7'b0110000;
            4'h4:    return 7'b0011001;
            4'h5:    return 7'b0010010;
            4'h6:    return 7'b0000010;
            4'h7:    return 7'b1111000;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0010000;
            4'hA:    return 7'b0001000;
            4'hB:    return 7'b0000011;
            4'hC:    return 7'b1000110;
            4'hD:    return 7'b0100001;
            4'hE:    return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // No bypass: a full FIFO refuses a push even on the edge it pops.
    assign PKT_READY = (cnt != CNT_FULL);
    assign push      = PKT_VALID && PKT_READY;
    // The head is taken on the edge that enters LOAD, so the occupancy
    // already reflects the pop while LOAD is on display.
    assign pop       = (state_next == S_LOAD);

    assign active    = (state == S_SHOW) || (state == S_GAP);
    assign run       = active && !PAUSE;
    assign tick      = run && (ps_cnt == PS_LAST);
    assign phase_end = tick && (hold_cnt == HC_LAST);

    // ---- FIFO storage (payload only, no reset) ----
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= PKT_DATA;
        end
        if (pop) begin
            pkt <= mem[rd_ptr];
        end
    end

    // ---- FIFO control ----
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // ---- Pacing: prescaler, hold counter, nibble index ----
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ps_cnt    <= '0;
            hold_cnt  <= '0;
            digit_idx <= '0;
        end else begin
            if (!active) begin
                ps_cnt <= '0;
            end else if (run) begin
                ps_cnt <= tick ? '0 : ps_cnt + PS_W'(1);
            end

            if (!active) begin
                hold_cnt <= '0;
            end else if (tick) begin
                hold_cnt <= phase_end ? '0 : hold_cnt + HC_W'(1);
            end

            if (pop) begin
                digit_idx <= IDX_LAST;
            end else if ((state == S_SHOW) && phase_end && (digit_idx != '0)) begin
                digit_idx <= digit_idx - IDX_W'(1);
            end
        end
    end

    // ---- FSM state register ----
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---- FSM next state ----
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: if (cnt != '0) state_next = S_LOAD;
            S_LOAD: state_next = S_SHOW;
            S_SHOW: if (phase_end && (digit_idx == '0)) state_next = S_GAP;
            S_GAP:  if (phase_end) state_next = (cnt != '0) ? S_LOAD : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ---- Display decode from registered state ----
    always_comb begin
        nib = 4'h0;
        for (int i = 0; i < NIB; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                nib = pkt[i*4 +: 4];
            end
        end
    end

    assign nHEX      = (state == S_SHOW) ? hex_seg(nib) : 7'h7F;
    assign DIGIT_IDX = digit_idx;
    assign BUSY      = (state != S_IDLE);
    assign FIFO_CNT  = cnt;

endmodule

// File: tb/tb_pkt_disp_sched.sv
// Bench for pkt_disp_sched: PACKET_W=8, DEPTH=2, DIV=4, HOLD=2.
// A transaction-level model predicts FIFO occupancy and busy time; every
// accepted packet queues its two expected nibbles, which a monitor pops
// whenever a new nibble appears on nHEX.
module tb_pkt_disp_sched;

    localparam int PW = 8;
    localparam int DP = 2;
    localparam int DV = 4;
    localparam int HD = 2;
    localparam int PHASE = HD * DV;
    // Advancing edges per packet after LOAD->SHOW: two nibbles plus a gap.
    localparam int ADV_PER_PKT = 3 * PHASE;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          PKT_VALID = 1'b0;
    logic [PW-1:0] PKT_DATA = '0;
    logic          PKT_READY;
    logic          PAUSE = 1'b0;
    logic [6:0]    nHEX;
    logic [0:0]    DIGIT_IDX;
    logic          BUSY;
    logic [1:0]    FIFO_CNT;

    pkt_disp_sched #(
        .PACKET_W(PW),
        .DEPTH   (DP),
        .DIV     (DV),
        .HOLD    (HD)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .PKT_VALID(PKT_VALID),
        .PKT_DATA (PKT_DATA),
        .PKT_READY(PKT_READY),
        .PAUSE    (PAUSE),
        .nHEX     (nHEX),
        .DIGIT_IDX(DIGIT_IDX),
        .BUSY     (BUSY),
        .FIFO_CNT (FIFO_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [6:0] seg;
        logic       idx;
    } nib_t;

    int checks = 0;
    int errors = 0;

    nib_t          sb_q[$];
    logic [PW-1:0] m_fifo[$];
    int            m_rem = 0;
    bit            m_skip = 1'b0;
    bit            m_busy = 1'b0;
    bit            m_pop = 1'b0;
    bit            m_push = 1'b0;
    bit            acc_evt = 1'b0;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, display as a budget of advancing
    // (non-paused) edges; a new packet may start once the budget is spent.
    initial begin
        forever begin
            @(posedge CLK or negedge nRST);
            if (!nRST) begin
                m_fifo.delete();
                sb_q.delete();
                m_rem   = 0;
                m_skip  = 1'b0;
                m_busy  = 1'b0;
                acc_evt = 1'b0;
            end else begin
                acc_evt = 1'b0;
                if (m_skip) begin
                    m_skip = 1'b0;
                end else if (m_rem > 0 && !PAUSE) begin
                    m_rem--;
                end
                m_pop  = (m_rem == 0) && !m_skip && (m_fifo.size() != 0);
                m_push = PKT_VALID && (m_fifo.size() != DP);
                if (m_pop) begin
                    void'(m_fifo.pop_front());
                    m_rem  = ADV_PER_PKT;
                    m_skip = 1'b1;
                end
                if (m_push) begin
                    nib_t e;
                    m_fifo.push_back(PKT_DATA);
                    e.seg = seg_of(PKT_DATA[7:4]); e.idx = 1'b1; sb_q.push_back(e);
                    e.seg = seg_of(PKT_DATA[3:0]); e.idx = 1'b0; sb_q.push_back(e);
                    acc_evt = 1'b1;
                end
                m_busy = (m_rem > 0);
            end
        end
    end

    // Monitor: per-cycle occupancy/busy against the model, and nibble/gap
    // events against the scoreboard.
    bit         in_run = 1'b0;
    bit         in_gap = 1'b0;
    int         run_len = 0, run_paused = 0;
    int         gap_len = 0, gap_paused = 0;
    logic [6:0] cur_seg = 7'h7F;
    logic       cur_idx = 1'b0;

    initial begin
        forever begin
            @(negedge CLK);
            if (!nRST) begin
                in_run = 1'b0;
                in_gap = 1'b0;
            end else begin
                chk("fifo_cnt", int'(FIFO_CNT), m_fifo.size());
                chk("pkt_ready", int'(PKT_READY), (m_fifo.size() != DP) ? 1 : 0);
                chk("busy", int'(BUSY), int'(m_busy));
                if (nHEX != 7'h7F) begin
                    if (!in_run || nHEX != cur_seg || DIGIT_IDX != cur_idx) begin
                        if (in_run) chk("nib_len", run_len, PHASE + run_paused);
                        if (in_gap) chk("gap_len_load", gap_len, PHASE + 1 + gap_paused);
                        in_gap = 1'b0;
                        if (sb_q.size() == 0) begin
                            chk("unexpected_nibble", int'(nHEX), 127);
                        end else begin
                            nib_t e;
                            e = sb_q.pop_front();
                            chk("nib_seg", int'(nHEX), int'(e.seg));
                            chk("nib_idx", int'(DIGIT_IDX), int'(e.idx));
                        end
                        in_run     = 1'b1;
                        run_len    = 0;
                        run_paused = 0;
                        cur_seg    = nHEX;
                        cur_idx    = DIGIT_IDX[0];
                    end
                    run_len++;
                    if (PAUSE) run_paused++;
                end else begin
                    if (in_run) begin
                        chk("nib_len", run_len, PHASE + run_paused);
                        in_run     = 1'b0;
                        in_gap     = 1'b1;
                        gap_len    = 0;
                        gap_paused = 0;
                    end
                    if (in_gap) begin
                        if (BUSY) begin
                            gap_len++;
                            if (PAUSE) gap_paused++;
                        end else begin
                            chk("gap_len_idle", gap_len, PHASE + gap_paused);
                            in_gap = 1'b0;
                        end
                    end
                end
            end
        end
    end

    task automatic send(input logic [PW-1:0] p);
        int t = 0;
        PKT_VALID = 1'b1;
        PKT_DATA  = p;
        do begin
            @(posedge CLK); #1;
            t++;
        end while (!acc_evt && t < 500);
        if (!acc_evt) chk("send_timeout", 0, 1);
        PKT_VALID = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int t = 0;
        @(negedge CLK);
        while ((BUSY || FIFO_CNT != 0) && t < limit) begin
            @(negedge CLK);
            t++;
        end
        chk("idle_timeout", (BUSY || FIFO_CNT != 0) ? 1 : 0, 0);
    endtask

    task automatic wait_show(input int limit);
        int t = 0;
        @(negedge CLK);
        while (nHEX == 7'h7F && t < limit) begin
            @(negedge CLK);
            t++;
        end
        chk("show_timeout", (nHEX == 7'h7F) ? 1 : 0, 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int  t;
        int  prev_cnt;
        bit  saw_full;
        bit  pause_push;
        logic idx0;
        logic [PW-1:0] sweep [8];

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_nhex", int'(nHEX), 127);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_cnt", int'(FIFO_CNT), 0);
        chk("rst_ready", int'(PKT_READY), 1);
        chk("rst_idx", int'(DIGIT_IDX), 0);
        nRST = 1'b1;
        @(posedge CLK); #1;

        // Single packet latency: pushed at edge k, LOAD after k+1, SHOW after k+2
        send(8'hA5);
        @(negedge CLK);
        chk("a5_cnt_k", int'(FIFO_CNT), 1);
        chk("a5_blank_k", int'(nHEX), 127);
        @(negedge CLK);
        chk("a5_cnt_load", int'(FIFO_CNT), 0);
        chk("a5_busy_load", int'(BUSY), 1);
        chk("a5_blank_load", int'(nHEX), 127);
        @(negedge CLK);
        chk("a5_first_seg", int'(nHEX), int'(7'b0001000));
        chk("a5_first_idx", int'(DIGIT_IDX), 1);
        wait_idle(200);

        // Back-to-back with VALID held high, then a push blocked by a full FIFO
        send(8'h01);
        send(8'h23);
        send(8'h45);
        PKT_VALID = 1'b1;
        PKT_DATA  = 8'h67;
        t = 0;
        saw_full = 1'b0;
        prev_cnt = -1;
        do begin
            @(negedge CLK);
            prev_cnt = int'(FIFO_CNT);
            if (FIFO_CNT == 2'd2 && !PKT_READY) saw_full = 1'b1;
            @(posedge CLK); #1;
            t++;
        end while (!acc_evt && t < 200);
        PKT_VALID = 1'b0;
        chk("b2b_accepted", int'(acc_evt), 1);
        chk("b2b_saw_full", int'(saw_full), 1);
        chk("b2b_cnt_before_push", prev_cnt, 1);
        @(negedge CLK);
        chk("b2b_cnt_after_push", int'(FIFO_CNT), 2);
        wait_idle(400);

        // Pause mid-nibble for 20 cycles while a new packet is pushed
        send(8'h3C);
        wait_show(50);
        repeat (3) @(negedge CLK);
        @(posedge CLK); #1;
        PAUSE     = 1'b1;
        PKT_VALID = 1'b1;
        PKT_DATA  = 8'h9E;
        pause_push = 1'b0;
        @(negedge CLK);
        idx0 = DIGIT_IDX[0];
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK); #1;
            if (acc_evt) begin
                PKT_VALID  = 1'b0;
                pause_push = 1'b1;
            end
            if (i == 19) begin
                chk("pause_idx_hold", int'(DIGIT_IDX), int'(idx0));
                chk("pause_fifo_cnt", int'(FIFO_CNT), 1);
                chk("pause_push_seen", int'(pause_push), 1);
                PAUSE = 1'b0;
            end
        end
        PKT_VALID = 1'b0;
        wait_idle(400);

        // Decode sweep across all sixteen hex digits
        sweep = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        foreach (sweep[i]) send(sweep[i]);
        wait_idle(600);

        // Asynchronous reset in the middle of a displayed nibble
        send(8'h5A);
        send(8'hC3);
        wait_show(50);
        repeat (2) @(negedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        chk("mid_rst_nhex", int'(nHEX), 127);
        chk("mid_rst_busy", int'(BUSY), 0);
        chk("mid_rst_cnt", int'(FIFO_CNT), 0);
        chk("mid_rst_ready", int'(PKT_READY), 1);
        chk("mid_rst_idx", int'(DIGIT_IDX), 0);
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        @(posedge CLK); #1;

        // Randomized traffic: bursts and idle stretches
        for (int n = 0; n < 30; n++) begin
            int gap;
            gap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 40)) : 0;
            repeat (gap) @(posedge CLK);
            #1;
            send(PW'($urandom_range(0, 255)));
        end

        wait_idle(2000);
        repeat (3) @(negedge CLK);
        chk("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
